// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block (pwm_multi_ch).
package pwm_pkg;

  localparam int PWM_WIDTH    = 8;
  localparam int PWM_CHANNELS = 4;

  typedef logic [PWM_WIDTH-1:0]              pwm_cnt_t;
  typedef logic [PWM_CHANNELS*PWM_WIDTH-1:0] pwm_duty_vec_t;

  typedef enum logic {
    PWM_UP   = 1'b0,
    PWM_DOWN = 1'b1
  } pwm_dir_e;

  // Channel i occupies bits [i*PWM_WIDTH +: PWM_WIDTH] of a packed duty vector.
  function automatic pwm_cnt_t duty_slice(input pwm_duty_vec_t vec, input int i);
    return vec[i*PWM_WIDTH +: PWM_WIDTH];
  endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: active duty register loaded on commit and a registered
// compare of the shared counter against that duty.
module pwm_channel_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] shadowDuty_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_q;
  logic             pwm_q;

  // The compare uses the duty active for this cycle; a commit only affects the next period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      if (commit_i) begin
        duty_q <= shadowDuty_i;
      end
      pwm_q <= enable_i && (cnt_i < duty_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with one shared period counter and a double-buffered period/duty set.
// Define PWM_CENTER_ALIGN_EN to add the center port and up/down (center-aligned) counting.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = PWM_CHANNELS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [WIDTH-1:0]          cfg_period_i,
  input  logic [CHANNELS*WIDTH-1:0] cfg_duty_i,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                      center_i,
`endif
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic                      period_tick_o
);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          period_q;
  logic [WIDTH-1:0]          shadowPeriod_q;
  logic [CHANNELS*WIDTH-1:0] shadowDuty_q;
  logic                      pending_q;
  logic                      periodTick_q;
  logic                      boundary;
  logic                      commit;
  logic                      transfer;

  assign transfer    = cfg_valid_i && !pending_q;
  assign commit      = pending_q && (boundary || !enable_i);
  assign cfg_ready_o = !pending_q;

`ifdef PWM_CENTER_ALIGN_EN
  pwm_dir_e dir_q, dir_d;
  logic     center_q;

  // Center mode folds at the top; periods of 0 or 1 have no down leg and wrap directly.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!center_q) begin
      if (cnt_q == period_q) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end
    end else if (dir_q == PWM_UP) begin
      if (cnt_q == period_q) begin
        if (period_q <= WIDTH'(1)) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          dir_d = PWM_DOWN;
        end
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == WIDTH'(1)) begin
        cnt_d    = '0;
        dir_d    = PWM_UP;
        boundary = 1'b1;
      end
    end
    if (!enable_i) begin
      cnt_d    = '0;
      dir_d    = PWM_UP;
      boundary = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q    <= PWM_UP;
      center_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      if (boundary || !enable_i) begin
        center_q <= center_i;
      end
    end
  end
`else
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    if (cnt_q == period_q) begin
      cnt_d    = '0;
      boundary = 1'b1;
    end
    if (!enable_i) begin
      cnt_d    = '0;
      boundary = 1'b0;
    end
  end
`endif

  // A transfer is only possible with nothing pending, so it never coincides with a commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      period_q       <= '1;
      shadowPeriod_q <= '0;
      shadowDuty_q   <= '0;
      pending_q      <= 1'b0;
      periodTick_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      periodTick_q <= boundary;
      if (commit) begin
        period_q  <= shadowPeriod_q;
        pending_q <= 1'b0;
      end
      if (transfer) begin
        shadowPeriod_q <= cfg_period_i;
        shadowDuty_q   <= cfg_duty_i;
        pending_q      <= 1'b1;
      end
    end
  end

  assign period_tick_o = periodTick_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
    logic [WIDTH-1:0] shadowSlice;
    if (WIDTH == PWM_WIDTH && CHANNELS == PWM_CHANNELS) begin : g_pkg
      assign shadowSlice = duty_slice(shadowDuty_q, c);
    end else begin : g_generic
      assign shadowSlice = shadowDuty_q[c*WIDTH +: WIDTH];
    end

    pwm_channel_cmp #(.WIDTH(WIDTH)) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .enable_i     (enable_i),
      .commit_i     (commit),
      .shadowDuty_i (shadowSlice),
      .cnt_i        (cnt_q),
      .pwm_o        (pwm_out_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: a position-within-period model checked every cycle,
// plus directed literal checks of waveforms, handshake, enable and reset behaviour.
`timescale 1ns/1ps
module tb_pwm_multi_ch;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfgValid;
  logic        cfgReady;
  logic [7:0]  cfgPeriod;
  logic [31:0] cfgDuty;
`ifdef PWM_CENTER_ALIGN_EN
  logic        center;
`endif
  logic [3:0]  pwmOut;
  logic        periodTick;

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: position in period, active and shadow configuration.
  int mPos, mPer, mPend, mCenter, sPer;
  int mDuty[4];
  int sDuty[4];
  logic [3:0] ePwm;
  logic       eTick, eReady;

  // Inputs as seen by the DUT at the last rising edge.
  bit          sampRst, sampEn, sampValid, sampCenter;
  logic [7:0]  sampPer;
  logic [31:0] sampDuty;

  int totHigh[4];
  int totTick;

  always #5 clk = ~clk;

  pwm_multi_ch #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .cfg_valid_i   (cfgValid),
    .cfg_ready_o   (cfgReady),
    .cfg_period_i  (cfgPeriod),
    .cfg_duty_i    (cfgDuty),
`ifdef PWM_CENTER_ALIGN_EN
    .center_i      (center),
`endif
    .pwm_out_o     (pwmOut),
    .period_tick_o (periodTick)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One period is P+1 cycles (edge) or 2P cycles (center, P>0); center value folds at P.
  task automatic modelStep();
    int  len;
    int  val;
    bit  last;
    bit  doCommit;
    bit  doXfer;
    if (sampRst) begin
      mPos = 0; mPer = 255; mPend = 0; mCenter = 0;
      for (int i = 0; i < 4; i++) mDuty[i] = 0;
      ePwm  = '0;
      eTick = 1'b0;
    end else begin
      len  = (mCenter != 0 && mPer != 0) ? 2 * mPer : mPer + 1;
      val  = (mCenter != 0 && mPos > mPer) ? 2 * mPer - mPos : mPos;
      last = sampEn && (mPos == len - 1);
      for (int i = 0; i < 4; i++) ePwm[i] = sampEn && (val < mDuty[i]);
      eTick    = last;
      doCommit = (mPend != 0) && (last || !sampEn);
      doXfer   = sampValid && (mPend == 0);
      if (!sampEn || last) begin
        mPos = 0;
`ifdef PWM_CENTER_ALIGN_EN
        mCenter = int'(sampCenter);
`endif
      end else begin
        mPos++;
      end
      if (doCommit) begin
        mPer  = sPer;
        mDuty = sDuty;
        mPend = 0;
      end
      if (doXfer) begin
        sPer = int'(sampPer);
        for (int i = 0; i < 4; i++) sDuty[i] = int'(duty_slice(sampDuty, i));
        mPend = 1;
      end
    end
    eReady = (mPend == 0);
  endtask

  task automatic stepCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      sampRst   = rst;
      sampEn    = enable;
      sampValid = cfgValid;
      sampPer   = cfgPeriod;
      sampDuty  = cfgDuty;
`ifdef PWM_CENTER_ALIGN_EN
      sampCenter = center;
`endif
      #1;
      modelStep();
      checkOutput("model_pwm_out", {28'd0, pwmOut}, {28'd0, ePwm});
      checkOutput("model_period_tick", {31'd0, periodTick}, {31'd0, eTick});
      checkOutput("model_cfg_ready", {31'd0, cfgReady}, {31'd0, eReady});
      for (int i = 0; i < 4; i++) totHigh[i] += int'(pwmOut[i]);
      totTick += int'(periodTick);
    end
  endtask

  task automatic waitReady(input int budget);
    int k = 0;
    while (cfgReady !== 1'b1 && k < budget) begin
      stepCycles(1);
      k++;
    end
    if (cfgReady !== 1'b1) checkOutput("wait_ready_timeout", {31'd0, cfgReady}, 32'd1);
  endtask

  task automatic waitTick(input int budget);
    int k = 0;
    while (periodTick !== 1'b1 && k < budget) begin
      stepCycles(1);
      k++;
    end
    if (periodTick !== 1'b1) checkOutput("wait_tick_timeout", {31'd0, periodTick}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] p, input logic [31:0] d);
    waitReady(40);
    cfgPeriod = p;
    cfgDuty   = d;
    cfgValid  = 1'b1;
    stepCycles(1);
    cfgValid  = 1'b0;
  endtask

  function automatic logic [31:0] packDuty(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  // Counts DUT high cycles per channel and ticks over a window against hand-computed totals.
  task automatic checkWindow(input string tag, input int cycles,
                             input int e0, input int e1, input int e2, input int e3, input int eT);
    int h0[4];
    int t0;
    for (int i = 0; i < 4; i++) h0[i] = totHigh[i];
    t0 = totTick;
    stepCycles(cycles);
    checkOutput({tag, "_ch0_high"}, totHigh[0] - h0[0], e0);
    checkOutput({tag, "_ch1_high"}, totHigh[1] - h0[1], e1);
    checkOutput({tag, "_ch2_high"}, totHigh[2] - h0[2], e2);
    checkOutput({tag, "_ch3_high"}, totHigh[3] - h0[3], e3);
    checkOutput({tag, "_ticks"}, totTick - t0, eT);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; cfgValid = 1'b0; cfgPeriod = '0; cfgDuty = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center = 1'b0;
`endif
    for (int i = 0; i < 4; i++) totHigh[i] = 0;
    totTick = 0;
    stepCycles(2);
    checkOutput("rst_pwm", {28'd0, pwmOut}, 32'd0);
    checkOutput("rst_ready", {31'd0, cfgReady}, 32'd1);
    checkOutput("rst_tick", {31'd0, periodTick}, 32'd0);
    rst = 1'b0;

    $display("[TB] test 1: P=9, duties 0/3/10/255");
    applyStimulus(8'd9, packDuty(0, 3, 10, 255));
    stepCycles(1);
    checkOutput("t1_ready_after_commit", {31'd0, cfgReady}, 32'd1);
    enable = 1'b1;
    stepCycles(1);
    checkOutput("t1_first_cycle", {28'd0, pwmOut}, 32'b1110);
    checkWindow("t1", 20, 0, 6, 20, 20, 2);

    $display("[TB] test 2: reload P=4 mid-period");
    waitTick(30);
    stepCycles(4);
    applyStimulus(8'd4, packDuty(0, 1, 10, 255));
    checkOutput("t2_ready_low", {31'd0, cfgReady}, 32'd0);
    stepCycles(4);
    checkOutput("t2_ready_still_low", {31'd0, cfgReady}, 32'd0);
    stepCycles(1);
    checkOutput("t2_ready_back", {31'd0, cfgReady}, 32'd1);
    checkOutput("t2_old_boundary_tick", {31'd0, periodTick}, 32'd1);
    stepCycles(1);
    checkOutput("t2_new_first", {28'd0, pwmOut}, 32'b1110);
    checkWindow("t2", 10, 0, 2, 10, 10, 2);

    $display("[TB] test 3: second offer while pending");
    applyStimulus(8'd4, packDuty(1, 2, 5, 0));
    cfgPeriod = 8'd7;
    cfgDuty   = packDuty(4, 5, 6, 7);
    cfgValid  = 1'b1;
    stepCycles(1);
    checkOutput("t3_still_pending", {31'd0, cfgReady}, 32'd0);
    cfgValid  = 1'b0;
    cfgDuty   = packDuty(9, 9, 9, 9);
    waitReady(20);
    stepCycles(1);
    checkWindow("t3", 10, 2, 4, 10, 0, 2);

    $display("[TB] test 4: enable low with a pending config");
    waitTick(20);
    stepCycles(2);
    applyStimulus(8'd6, packDuty(3, 0, 7, 2));
    enable = 1'b0;
    stepCycles(1);
    checkOutput("t4_off_pwm", {28'd0, pwmOut}, 32'd0);
    checkOutput("t4_off_tick", {31'd0, periodTick}, 32'd0);
    checkOutput("t4_commit_while_off", {31'd0, cfgReady}, 32'd1);
    stepCycles(2);
    checkOutput("t4_off_pwm_late", {28'd0, pwmOut}, 32'd0);
    enable = 1'b1;
    stepCycles(1);
    checkOutput("t4_restart_cnt0", {28'd0, pwmOut}, 32'b1101);
    stepCycles(2);
    checkOutput("t4_cnt2", {28'd0, pwmOut}, 32'b0101);
    stepCycles(1);
    checkOutput("t4_cnt3", {28'd0, pwmOut}, 32'b0100);
    stepCycles(3);
    checkOutput("t4_tick_at_cnt6", {31'd0, periodTick}, 32'd1);
    checkWindow("t4", 14, 6, 0, 14, 4, 2);

    $display("[TB] test 5: reset with a config pending");
    applyStimulus(8'd3, packDuty(2, 2, 2, 2));
    stepCycles(1);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("t5_rst_pwm", {28'd0, pwmOut}, 32'd0);
    checkOutput("t5_rst_ready", {31'd0, cfgReady}, 32'd1);
    checkOutput("t5_rst_tick", {31'd0, periodTick}, 32'd0);
    rst = 1'b0;
    checkWindow("t5", 30, 0, 0, 0, 0, 0);

`ifdef PWM_CENTER_ALIGN_EN
    $display("[TB] test 6: center-aligned P=4, ch0 duty 2");
    enable = 1'b0;
    center = 1'b1;
    applyStimulus(8'd4, packDuty(2, 0, 0, 0));
    stepCycles(1);
    enable = 1'b1;
    stepCycles(1);
    checkOutput("t6_first", {28'd0, pwmOut}, 32'b0001);
    checkWindow("t6", 16, 6, 0, 0, 0, 2);
    waitTick(20);
    stepCycles(7);
    checkOutput("t6_no_tick_mid", {31'd0, periodTick}, 32'd0);
    stepCycles(1);
    checkOutput("t6_tick_period8", {31'd0, periodTick}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
